instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Registered, parametrised RISC-V decode stage between fetch and execute. Splits each 32-bit instruction into fields and classifies its format (R/I/S/B/U/J/illegal). Also produces the format-correct, sign-extended immediate. Decoded results move downstream through a valid/ready handshake with a two-entry skid buffer, support pipeline flush, and maintain saturating decode/illegal counters.

## Interface

**Parameters**
- `XLEN`, default 32: immediate/PC width; 32 or 64.
- `CNT_W`, default 16: width of each statistics counter.
- `SKID_EN`, default 1: 1 enables the two-entry skid buffer; 0 uses a single register.

**Ports**
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept.
- `in_instr` input 32: raw instruction.
- `in_pc` input XLEN: instruction address.
- `flush` input 1: discard all held entries.
- `out_valid` output 1: decoded entry available.
- `out_ready` input 1: execute accepts.
- `out_pc` output XLEN: passthrough PC.
- `opcode` output 7, `funct3` output 3, `funct7` output 7, `rd` output 5, `rs1` output 5, `rs2` output 5, `csr` output 12: raw fields of the held instruction.
- `fmt` output 3: `fmt_t` format code.
- `imm` output XLEN: sign-extended immediate.
- `illegal` output 1: unsupported encoding.
- `dec_cnt` output CNT_W: entries accepted downstream.
- `ill_cnt` output CNT_W: illegal entries accepted downstream.

## Operation

**Format by opcode**
- R: `0110011`.
- I: `0010011`, `0000011`, `1100111`, `1110011`.
- S: `0100011`.
- B: `1100011`.
- U: `0110111`, `0010111`.
- J: `1101111`.
- Anything else, or `instr[1:0]≠2'b11`: ILL, with `illegal=1`.

**Immediate**
- I: `instr[31:20]`.
- S: `{[31:25],[11:7]}`.
- B: `{[31],[7],[30:25],[11:8],0}`.
- U: `{[31:12],12'b0}`.
- J: `{[31],[19:12],[20],[30:21],0}`.
- All immediates are sign-extended from `instr[31]` to XLEN.
- R and ILL: imm = 0.

**Fields and buffering**
- Raw fields are always driven from the held instruction, regardless of format.
- Entries: main register (drives outputs) and skid register.
  - Accept when `in_valid && in_ready`.
  - If main is empty or draining that cycle, the new entry goes to main; otherwise it goes to skid.
  - When main drains and skid is full, skid moves to main.
- `in_ready` = skid empty. It is registered and has no combinational path from `out_ready`.
- `SKID_EN=0`: single register; `in_ready = !out_valid || out_ready`.
- Order is strictly FIFO. No entry is lost or duplicated.

**Flush**
- Both entries are invalidated at the next edge.
- An input offered in the same cycle as `flush` is dropped.
- Counters are not affected by flushed entries.

**Counters**
- `dec_cnt` increments on `out_valid && out_ready`.
- `ill_cnt` increments on the same condition when `illegal=1`.
- Both saturate at all-ones; they do not wrap.

## Timing

- Latency: 1 cycle from input handshake to `out_valid`, with a fully registered output.
- Throughput: 1 instruction per cycle while `out_ready=1`.
- Reset: `out_valid=0`, all field outputs 0, `fmt=FMT_R`, `imm=0`, `illegal=0`, both counters 0, both entries empty. `in_ready=1` from the first cycle after reset deasserts.
- Reset mid-stream: held entries are discarded, with no output handshake.
- Both entries full while `out_ready=0`: `in_ready=0` in the following cycle, and outputs are held stable.
- Simultaneous input accept and output drain with skid empty: main reloads directly, so `out_valid` stays 1.
- `flush` and `rst` take priority over every handshake in the same cycle.
- A counter at max with another handshake stays at max.

## Structure

- Package `decode_pkg`:
  - `fmt_t` enum: R, I, S, B, U, J, ILL.
  - Opcode localparams.
  - `decoded_t` packed struct holding all fields, `fmt`, `imm`, `illegal` and `pc`. Entry registers store `decoded_t`.
- Sub-module `imm_gen`: combinational; instruction in → `fmt`, `imm` (XLEN), `illegal` out. It is instantiated once, on the input side, so decoding happens before registering.

## Test plan

1. `0xFFB10093` (addi x1,x2,-5) → next cycle `fmt=I`, `rd=1`, `rs1=2`, `funct3=0`, `imm=0xFFFFFFFB`, `out_valid=1`.
2. `0x00512423` (sw x5,8(x2)) → `fmt=S`, `rs1=2`, `rs2=5`, `imm=8`. Then `0xFE000EE3` (beq x0,x0,-4) → `fmt=B`, `imm=0xFFFFFFFC`.
3. `0x123451B7` (lui x3,0x12345) → `fmt=U`, `rd=3`, `imm=0x12345000`. With `XLEN=64` and `0x800000B7` → `imm=0xFFFFFFFF80000000`.
4. Backpressure, `out_ready=0`, three back-to-back instructions → first two held, `in_ready=0` after the second accept, third not accepted. Raise `out_ready` → outputs in order A, B, C on consecutive cycles; `dec_cnt=3`.
5. `0x00000000` → `fmt=ILL`, `illegal=1`, `imm=0`. After its output handshake, `ill_cnt=1` and `dec_cnt=1`.
6. Both entries full, then assert `flush` with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, counters unchanged. Separately, preload `dec_cnt=0xFFFF` and perform a handshake → `dec_cnt` stays `0xFFFF`.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RISC-V decode stage.
//   fmt_t     : instruction format classification
//   OPC_*     : major opcodes recognised by the decoder
//   decoded_t : one decoded entry as held in the stage registers
package decode_pkg;

  // Widest supported XLEN; entries carry pc/imm at this width and the
  // top slices them down to the configured XLEN.
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [11:0]         csr;
    fmt_t                fmt;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational format classifier and immediate generator.
//   instr   : raw 32-bit instruction
//   fmt     : format code
//   imm     : format-correct immediate, sign-extended from instr[31] to XLEN
//   illegal : encoding not supported
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    // Every listed opcode ends in 2'b11, so compressed/reserved encodings
    // fall through to FMT_ILL without a separate instr[1:0] check.
    unique case (instr[6:0])
      OPC_OP:                                      fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  fmt = FMT_I;
      OPC_STORE:                                   fmt = FMT_S;
      OPC_BRANCH:                                  fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                          fmt = FMT_U;
      OPC_JAL:                                     fmt = FMT_J;
      default:                                     fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    unique case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm     = XLEN'(signed'(imm32));
  assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RISC-V decode stage with valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : fetch-side handshake; in_instr, in_pc payload
//   flush                : drop every held entry and any same-cycle input
//   out_valid/out_ready  : execute-side handshake
//   out_pc, opcode..csr  : passthrough pc and raw fields of the head entry
//   fmt, imm, illegal    : decode results of the head entry
//   dec_cnt, ill_cnt     : saturating counts of entries / illegal entries drained
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CNT_W   = 16,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [11:0]      csr,
  output fmt_t             fmt,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  decoded_t in_dec;

  always_comb begin
    in_dec         = '0;
    in_dec.pc      = XLEN_MAX'(in_pc);
    in_dec.imm     = XLEN_MAX'(dec_imm);
    in_dec.opcode  = in_instr[6:0];
    in_dec.rd      = in_instr[11:7];
    in_dec.funct3  = in_instr[14:12];
    in_dec.rs1     = in_instr[19:15];
    in_dec.rs2     = in_instr[24:20];
    in_dec.funct7  = in_instr[31:25];
    in_dec.csr     = in_instr[31:20];
    in_dec.fmt     = dec_fmt;
    in_dec.illegal = dec_ill;
  end

  decoded_t        main_q, main_d, skid_q, skid_d;
  logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
  logic            accept, drain;

  if (SKID_EN) begin : g_skid
    // Registered: depends only on skid occupancy, never on out_ready.
    assign in_ready = !skid_vld_q;
  end else begin : g_single
    assign in_ready = !main_vld_q || out_ready;
  end

  assign accept = in_valid && in_ready;
  assign drain  = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        // in_ready is low whenever skid is occupied, so no input competes here.
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      // Only reachable with the skid enabled; single-register mode never
      // accepts while main is held.
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
  end

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (drain && !flush) begin
      if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + 1'b1;
      if (main_q.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      dec_cnt_q  <= '0;
      ill_cnt_q  <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      dec_cnt_q  <= dec_cnt_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
  end

  assign out_valid = main_vld_q;
  assign out_pc    = main_q.pc[XLEN-1:0];
  assign imm       = main_q.imm[XLEN-1:0];
  assign opcode    = main_q.opcode;
  assign funct3    = main_q.funct3;
  assign funct7    = main_q.funct7;
  assign rd        = main_q.rd;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign csr       = main_q.csr;
  assign fmt       = main_q.fmt;
  assign illegal   = main_q.illegal;
  assign dec_cnt   = dec_cnt_q;
  assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  import decode_pkg::*;

  localparam int CW   = 7;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: XLEN=32, skid enabled, narrow counters so saturation is reached.
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] csr;
  fmt_t        fmt;
  logic [CW-1:0] dec_cnt, ill_cnt;

  instr_decode_stage #(.XLEN(32), .CNT_W(CW), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .csr(csr), .fmt(fmt), .imm(imm), .illegal(illegal), .dec_cnt(dec_cnt),
    .ill_cnt(ill_cnt)
  );

  // Second DUT: XLEN=64, single register.
  logic        v64, rdy64, ordy64, ovld64, ill64, fl64;
  logic [31:0] i64;
  logic [63:0] p64, opc64, imm64;
  logic [6:0]  x_op, x_f7;
  logic [2:0]  x_f3;
  logic [4:0]  x_rd, x_rs1, x_rs2;
  logic [11:0] x_csr;
  fmt_t        fmt64;
  logic [15:0] dcnt64, icnt64;

  instr_decode_stage #(.XLEN(64), .CNT_W(16), .SKID_EN(1'b0)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .in_instr(i64), .in_pc(p64),
    .flush(fl64), .out_valid(ovld64), .out_ready(ordy64), .out_pc(opc64), .opcode(x_op),
    .funct3(x_f3), .funct7(x_f7), .rd(x_rd), .rs1(x_rs1), .rs2(x_rs2), .csr(x_csr),
    .fmt(fmt64), .imm(imm64), .illegal(ill64), .dec_cnt(dcnt64), .ill_cnt(icnt64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    bit          ill;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   m_dec = 0, m_ill = 0;
  bit   chk_en = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: format codes follow the enum order R,I,S,B,U,J,ILL = 0..6.
  function automatic int ref_fmt(logic [31:0] ins);
    if (ins[1:0] != 2'b11) return 6;
    case (ins[6:0])
      7'b0110011:                                     return 0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 1;
      7'b0100011:                                     return 2;
      7'b1100011:                                     return 3;
      7'b0110111, 7'b0010111:                         return 4;
      7'b1101111:                                     return 5;
      default:                                        return 6;
    endcase
  endfunction

  function automatic longint sx(longint v, int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] ins, int xlen);
    longint u = longint'(ins);
    longint v;
    logic [63:0] r;
    case (ref_fmt(ins))
      1: v = sx((u >> 20) & 'hFFF, 12);
      2: v = sx((((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F), 12);
      3: v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 'h3F) << 5)
                | (((u >> 8) & 'hF) << 1), 13);
      4: v = sx(u & 'hFFFFF000, 32);
      5: v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12) | (((u >> 20) & 1) << 11)
                | (((u >> 21) & 'h3FF) << 1), 21);
      default: v = 0;
    endcase
    r = 64'(v);
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic exp_t mk(logic [31:0] ins, logic [31:0] pc);
    exp_t x;
    x.instr = ins;
    x.pc    = pc;
    x.fmt   = 3'(ref_fmt(ins));
    x.imm   = ref_imm(ins, 32);
    x.ill   = (ref_fmt(ins) == 6);
    return x;
  endfunction

  // Monitor: compares what the DUT presents against the queue head, then
  // applies this edge's reset / flush / drain to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("dec_cnt", 64'(dec_cnt), 64'(m_dec));
      chk("ill_cnt", 64'(ill_cnt), 64'(m_ill));
      if (q.size() != 0 && out_valid) begin
        e = q[0];
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("opcode", 64'(opcode), 64'(e.instr & 32'h7F));
        chk("rd", 64'(rd), 64'((e.instr >> 7) & 32'h1F));
        chk("funct3", 64'(funct3), 64'((e.instr >> 12) & 32'h7));
        chk("rs1", 64'(rs1), 64'((e.instr >> 15) & 32'h1F));
        chk("rs2", 64'(rs2), 64'((e.instr >> 20) & 32'h1F));
        chk("funct7", 64'(funct7), 64'(e.instr >> 25));
        chk("csr", 64'(csr), 64'(e.instr >> 20));
        chk("fmt", 64'(fmt), 64'(e.fmt));
        chk("imm", 64'(imm), e.imm);
        chk("illegal", 64'(illegal), 64'(e.ill));
      end
    end
    if (rst) begin
      q.delete();
      m_dec = 0;
      m_ill = 0;
    end else if (flush) begin
      q.delete();
    end else if (q.size() != 0 && out_ready) begin
      e = q.pop_front();
      if (m_dec < CMAX) m_dec++;
      if (e.ill && m_ill < CMAX) m_ill++;
    end
  end

  logic [31:0] pcv = 32'h0000_1000;

  // Drives one cycle from posedge+1 and pushes the expected entry if the
  // input handshake will complete at the coming edge.
  task automatic drive_cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                             input bit ordy, input bit fl, input bit r, output bit acc);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    #1;
    acc = v && in_ready && !fl && !r;
    if (acc) q.push_back(mk(ins, pc));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      drive_cycle(1'b1, ins, pcv, 1'b1, 1'b0, 1'b0, acc);
      n++;
    end
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_timeout: instr 0x%08h not accepted within 50 cycles", ins);
    end
    pcv += 4;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, acc);
  endtask

  logic [6:0] ops [0:9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    if ($urandom_range(99) < 65) r[6:0] = ops[$urandom_range(9)];
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    bit acc, v, ordy, fl, r, have;
    logic [31:0] cur, cpc;
    logic [31:0] lst [0:7];

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    v64 = 1'b0; i64 = '0; p64 = '0; ordy64 = 1'b1; fl64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", 64'({opcode, funct3, funct7, rd, rs1, rs2, csr}), 64'd0);
    chk("rst_fmt", 64'(fmt), 64'(FMT_R));
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_cnts", 64'({dec_cnt, ill_cnt}), 64'd0);
    chk_en = 1'b1;

    // Directed decodes.
    send(32'hFFB10093);
    chk("addi_imm", 64'(imm), 64'hFFFF_FFFB);
    chk("addi_rd_rs1", 64'({rd, rs1}), 64'({5'd1, 5'd2}));
    send(32'h00512423);
    chk("sw_imm", 64'(imm), 64'd8);
    send(32'hFE000EE3);
    chk("beq_imm", 64'(imm), 64'hFFFF_FFFC);
    send(32'h123451B7);
    chk("lui_imm", 64'(imm), 64'h1234_5000);
    send(32'h00000000);
    chk("zero_illegal", 64'(illegal), 64'd1);
    idle(3, 1'b1);

    // Backpressure: A and B fill both entries, C waits.
    drive_cycle(1'b1, 32'h00A00093, pcv, 1'b0, 1'b0, 1'b0, acc); pcv += 4;
    drive_cycle(1'b1, 32'h00B00113, pcv, 1'b0, 1'b0, 1'b0, acc); pcv += 4;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h00C00193, pcv, 1'b0, 1'b0, 1'b0, acc);
    send(32'h00C00193);
    idle(4, 1'b1);

    // Flush with both entries full and an input offered.
    drive_cycle(1'b1, 32'h00100093, pcv, 1'b0, 1'b0, 1'b0, acc); pcv += 4;
    drive_cycle(1'b1, 32'h00200093, pcv, 1'b0, 1'b0, 1'b0, acc); pcv += 4;
    drive_cycle(1'b1, 32'h00300093, pcv, 1'b0, 1'b1, 1'b0, acc); pcv += 4;
    idle(3, 1'b1);

    // Randomised traffic with occasional flush and one mid-stream reset.
    have = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!have) begin
        cur = rnd_instr();
        cpc = pcv;
        pcv += 4;
        have = 1'b1;
      end
      v    = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      fl   = ($urandom_range(39) == 0);
      r    = (c == 300);
      drive_cycle(v, cur, cpc, ordy, fl, r, acc);
      if (acc || (v && (fl || r))) have = 1'b0;
    end
    idle(4, 1'b1);
    chk("dec_saturated", 64'(dec_cnt), 64'(CMAX));

    // XLEN=64, single-register instance.
    chk_en = 1'b0;
    lst = '{32'h800000B7, 32'hFFB10093, 32'hFE000EE3, 32'h00000000, 32'h00512423,
            32'hFFDFF06F, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      v64 = 1'b1;
      i64 = lst[k];
      p64 = 64'hFFFF_0000_0000_0000 + 64'(k * 4);
      ordy64 = 1'b1;
      @(posedge clk);
      #1;
      chk("x64_valid", 64'(ovld64), 64'd1);
      chk("x64_imm", imm64, ref_imm(lst[k], 64));
      chk("x64_fmt", 64'(fmt64), 64'(ref_fmt(lst[k])));
      chk("x64_pc", opc64, 64'hFFFF_0000_0000_0000 + 64'(k * 4));
    end
    ordy64 = 1'b0;
    i64 = 32'h123451B7;
    #1;
    chk("x64_ready_stall", 64'(rdy64), 64'd0);
    @(posedge clk);
    #1;
    chk("x64_hold_imm", imm64, ref_imm(lst[7], 64));
    ordy64 = 1'b1;
    #1;
    chk("x64_ready_go", 64'(rdy64), 64'd1);
    @(posedge clk);
    #1;
    chk("x64_lui_imm", imm64, 64'h0000_0000_1234_5000);
    v64 = 1'b0;
    @(posedge clk);
    #1;
    chk("x64_drained", 64'(ovld64), 64'd0);
    chk("x64_dec_cnt", 64'(dcnt64), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
